// File: rtl/tpu_pkg.sv
// Shared widths, FSM encoding and latched-config struct for the loss-stage sequencer.
// Purely declarative; nothing here carries state, so it has no latency or backpressure of its own.
package tpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    // Q8.8 unity, kept here so scale arithmetic around the loss stage shares one definition
    localparam logic [DATA_W-1:0] ONE = 16'h0100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rows;
        logic [ADDR_W-1:0] grad_base;
        logic [DATA_W-1:0] scale;
    } cfg_t;

endpackage

// File: rtl/grad_deskew_fifo.sv
// Four-entry FIFO that holds column-1 gradients until the matching column-2 gradient arrives.
// Zero-latency pop (head always visible); a push into a full FIFO is accepted only alongside a pop.
module grad_deskew_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [0:3];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic [2:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full     = (count == 3'd4);
    assign empty    = (count == 3'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/loss_sequencer.sv
// Batch controller for the two-column loss stage: row reads with column-2 skew, gradient deskew and write-back.
// Column 1 valid RD_LAT+1 cycles after rd_en, column 2 one cycle later; no backpressure, deskew errors are sticky.
module loss_sequencer
    import tpu_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_in,
    input  logic [ADDR_W-1:0]   num_rows_in,
    input  logic [ADDR_W-1:0]   h_base_in,
    input  logic [ADDR_W-1:0]   y_base_in,
    input  logic [ADDR_W-1:0]   grad_base_in,
    input  logic [DATA_W-1:0]   inv_bs2_in,
    output logic                rd_en_out,
    output logic [ADDR_W-1:0]   rd_h_addr_out,
    output logic [ADDR_W-1:0]   rd_y_addr_out,
    input  logic [2*DATA_W-1:0] rd_h_data_in,
    input  logic [2*DATA_W-1:0] rd_y_data_in,
    output logic [DATA_W-1:0]   H_1_out,
    output logic [DATA_W-1:0]   Y_1_out,
    output logic [DATA_W-1:0]   H_2_out,
    output logic [DATA_W-1:0]   Y_2_out,
    output logic                valid_1_out,
    output logic                valid_2_out,
    output logic [DATA_W-1:0]   inv_bs2_out,
    input  logic [DATA_W-1:0]   grad_1_in,
    input  logic [DATA_W-1:0]   grad_2_in,
    input  logic                grad_valid_1_in,
    input  logic                grad_valid_2_in,
    output logic                wr_en_out,
    output logic [ADDR_W-1:0]   wr_addr_out,
    output logic [2*DATA_W-1:0] wr_data_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                err_out
);

    state_t            state;
    cfg_t              cfg;
    logic [ADDR_W-1:0] issued;
    logic [ADDR_W-1:0] written;

    logic [RD_LAT-1:0] rd_pipe;
    logic              data_vld;
    logic [DATA_W-1:0] h2_skew;
    logic [DATA_W-1:0] y2_skew;
    logic              skew_vld;

    logic              active;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              start_ok;

    assign inv_bs2_out = cfg.scale;
    assign data_vld    = rd_pipe[RD_LAT-1];
    assign start_ok    = (state == IDLE) && start_in;

    // Gradients are only meaningful while a batch is in flight; stragglers after an abort are dropped
    assign active    = (state == ISSUE) || (state == DRAIN);
    assign fifo_pop  = active && grad_valid_2_in && !fifo_empty;
    assign fifo_push = active && grad_valid_1_in && (!fifo_full || fifo_pop);

    grad_deskew_fifo #(.W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .push      (fifo_push),
        .push_data (grad_1_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cfg           <= '0;
            issued        <= '0;
            written       <= '0;
            rd_en_out     <= 1'b0;
            rd_h_addr_out <= '0;
            rd_y_addr_out <= '0;
            wr_en_out     <= 1'b0;
            wr_addr_out   <= '0;
            wr_data_out   <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            err_out       <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        cfg.rows      <= num_rows_in;
                        cfg.grad_base <= grad_base_in;
                        cfg.scale     <= inv_bs2_in;
                        err_out       <= 1'b0;
                        written       <= '0;
                        if (num_rows_in == '0) begin
                            state    <= DONE;
                            done_out <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            busy_out      <= 1'b1;
                            rd_en_out     <= 1'b1;
                            rd_h_addr_out <= h_base_in;
                            rd_y_addr_out <= y_base_in;
                            issued        <= 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (issued == cfg.rows) begin
                        rd_en_out <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        rd_h_addr_out <= rd_h_addr_out + 1'b1;
                        rd_y_addr_out <= rd_y_addr_out + 1'b1;
                        issued        <= issued + 1'b1;
                    end
                end
                DRAIN: begin
                    if (written == cfg.rows) begin
                        state    <= DONE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            wr_en_out <= fifo_pop;
            if (fifo_pop) begin
                wr_addr_out <= cfg.grad_base + written;
                wr_data_out <= {grad_2_in, fifo_head};
                written     <= written + 1'b1;
            end
            if (active && ((grad_valid_2_in && fifo_empty) ||
                           (grad_valid_1_in && fifo_full && !fifo_pop)))
                err_out <= 1'b1;
        end
    end

    // Read-data alignment: column 1 registered once, column 2 passes through an extra skew stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe     <= '0;
            h2_skew     <= '0;
            y2_skew     <= '0;
            skew_vld    <= 1'b0;
            H_1_out     <= '0;
            Y_1_out     <= '0;
            H_2_out     <= '0;
            Y_2_out     <= '0;
            valid_1_out <= 1'b0;
            valid_2_out <= 1'b0;
        end else begin
            rd_pipe[0] <= rd_en_out;
            for (int i = 1; i < RD_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
            valid_1_out <= data_vld;
            skew_vld    <= data_vld;
            valid_2_out <= skew_vld;
            if (data_vld) begin
                H_1_out <= rd_h_data_in[DATA_W-1:0];
                Y_1_out <= rd_y_data_in[DATA_W-1:0];
                h2_skew <= rd_h_data_in[2*DATA_W-1:DATA_W];
                y2_skew <= rd_y_data_in[2*DATA_W-1:DATA_W];
            end
            if (skew_vld) begin
                H_2_out <= h2_skew;
                Y_2_out <= y2_skew;
            end
        end
    end

endmodule

// File: tb/tb_loss_sequencer.sv
// Randomized scoreboard bench for loss_sequencer with buffer and two-cycle loss-stage models.
`timescale 1ns/1ps
module tb_loss_sequencer;
    import tpu_pkg::*;

    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                start_in;
    logic [ADDR_W-1:0]   num_rows_in, h_base_in, y_base_in, grad_base_in;
    logic [DATA_W-1:0]   inv_bs2_in;
    logic                rd_en_out;
    logic [ADDR_W-1:0]   rd_h_addr_out, rd_y_addr_out;
    logic [2*DATA_W-1:0] rd_h_data_in, rd_y_data_in;
    logic [DATA_W-1:0]   H_1_out, Y_1_out, H_2_out, Y_2_out, inv_bs2_out;
    logic                valid_1_out, valid_2_out;
    logic [DATA_W-1:0]   grad_1_in, grad_2_in;
    logic                grad_valid_1_in, grad_valid_2_in;
    logic                wr_en_out;
    logic [ADDR_W-1:0]   wr_addr_out;
    logic [2*DATA_W-1:0] wr_data_out;
    logic                busy_out, done_out, err_out;
    logic                inj_v2;

    loss_sequencer #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .num_rows_in(num_rows_in),
        .h_base_in(h_base_in), .y_base_in(y_base_in), .grad_base_in(grad_base_in),
        .inv_bs2_in(inv_bs2_in), .rd_en_out(rd_en_out), .rd_h_addr_out(rd_h_addr_out),
        .rd_y_addr_out(rd_y_addr_out), .rd_h_data_in(rd_h_data_in), .rd_y_data_in(rd_y_data_in),
        .H_1_out(H_1_out), .Y_1_out(Y_1_out), .H_2_out(H_2_out), .Y_2_out(Y_2_out),
        .valid_1_out(valid_1_out), .valid_2_out(valid_2_out), .inv_bs2_out(inv_bs2_out),
        .grad_1_in(grad_1_in), .grad_2_in(grad_2_in), .grad_valid_1_in(grad_valid_1_in),
        .grad_valid_2_in(grad_valid_2_in), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out), .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [DATA_W-1:0] loss_f(input logic [15:0] h, input logic [15:0] y,
                                                 input logic [15:0] s);
        logic signed [16:0] d;
        logic signed [33:0] p;
        d = $signed({h[15], h}) - $signed({y[15], y});
        p = d * $signed(s);
        return p[23:8];
    endfunction

    // Unified buffer: contents fixed at time zero, data appears RD_LAT cycles after the address
    logic [2*DATA_W-1:0] mem_h [0:255];
    logic [2*DATA_W-1:0] mem_y [0:255];
    logic [2*DATA_W-1:0] bh [0:3];
    logic [2*DATA_W-1:0] by [0:3];
    always @(posedge clk) begin
        bh[0] <= mem_h[rd_h_addr_out];
        by[0] <= mem_y[rd_y_addr_out];
        for (int i = 1; i < 4; i++) begin
            bh[i] <= bh[i-1];
            by[i] <= by[i-1];
        end
    end
    assign rd_h_data_in = bh[RD_LAT-1];
    assign rd_y_data_in = by[RD_LAT-1];

    // Loss stage: grad = (H - Y) * scale in Q8.8, two cycles per column
    logic [1:0]        lv1 = '0, lv2 = '0;
    logic [DATA_W-1:0] lg1 [0:1];
    logic [DATA_W-1:0] lg2 [0:1];
    always @(posedge clk) begin
        lv1[0] <= valid_1_out;
        lg1[0] <= loss_f(H_1_out, Y_1_out, inv_bs2_out);
        lv2[0] <= valid_2_out;
        lg2[0] <= loss_f(H_2_out, Y_2_out, inv_bs2_out);
        lv1[1] <= lv1[0];
        lg1[1] <= lg1[0];
        lv2[1] <= lv2[0];
        lg2[1] <= lg2[0];
    end
    assign grad_valid_1_in = lv1[1];
    assign grad_1_in       = lg1[1];
    assign grad_valid_2_in = lv2[1] | inj_v2;
    assign grad_2_in       = lg2[1];

    logic [15:0] rdq [$];
    logic [31:0] c1q [$];
    logic [31:0] c2q [$];
    logic [39:0] wrq [$];
    logic [DATA_W-1:0] exp_scale = '0;
    int done_cnt = 0;
    int wr_cnt = 0;

    logic [3:0]  hist = '0;
    logic        v1d = 1'b0;
    logic [39:0] m_exp;

    always @(negedge clk) begin
        if (rst) begin
            hist = '0;
            v1d  = 1'b0;
        end else begin
            if (rd_en_out) begin
                if (rdq.size() == 0) unexp("rd_unexpected", {rd_h_addr_out, rd_y_addr_out});
                else begin
                    m_exp = {24'd0, rdq.pop_front()};
                    chk("rd_addr", {rd_h_addr_out, rd_y_addr_out}, m_exp);
                end
            end
            if (valid_1_out || hist[RD_LAT]) chk("valid_1_latency", valid_1_out, hist[RD_LAT]);
            if (valid_2_out || v1d) chk("valid_2_skew", valid_2_out, v1d);
            if (valid_1_out) begin
                if (c1q.size() == 0) unexp("col1_unexpected", {H_1_out, Y_1_out});
                else begin
                    m_exp = {8'd0, c1q.pop_front()};
                    chk("col1_data", {H_1_out, Y_1_out}, m_exp);
                end
            end
            if (valid_2_out) begin
                if (c2q.size() == 0) unexp("col2_unexpected", {H_2_out, Y_2_out});
                else begin
                    m_exp = {8'd0, c2q.pop_front()};
                    chk("col2_data", {H_2_out, Y_2_out}, m_exp);
                end
            end
            if (wr_en_out) begin
                wr_cnt++;
                if (wrq.size() == 0) unexp("wr_unexpected", {wr_addr_out, wr_data_out});
                else begin
                    m_exp = wrq.pop_front();
                    chk("wr_addr_data", {wr_addr_out, wr_data_out}, m_exp);
                end
            end
            if (busy_out) chk("scale_latched", inv_bs2_out, exp_scale);
            if (done_out) done_cnt++;
            hist = {hist[2:0], rd_en_out};
            v1d  = valid_1_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int rows, input logic [7:0] hb, input logic [7:0] yb,
                               input logic [7:0] gb, input logic [15:0] sc);
        logic [7:0] ha, ya, ga;
        logic [31:0] h, y;
        for (int k = 0; k < rows; k++) begin
            ha = hb + 8'(k);
            ya = yb + 8'(k);
            ga = gb + 8'(k);
            h  = mem_h[ha];
            y  = mem_y[ya];
            rdq.push_back({ha, ya});
            c1q.push_back({h[15:0], y[15:0]});
            c2q.push_back({h[31:16], y[31:16]});
            wrq.push_back({ga, loss_f(h[31:16], y[31:16], sc), loss_f(h[15:0], y[15:0], sc)});
        end
        exp_scale    = sc;
        num_rows_in  = 8'(rows);
        h_base_in    = hb;
        y_base_in    = yb;
        grad_base_in = gb;
        inv_bs2_in   = sc;
        start_in     = 1'b1;
    endtask

    task automatic run_batch(input int rows, input logic [7:0] hb, input logic [7:0] yb,
                             input logic [7:0] gb, input logic [15:0] sc,
                             input bit spam, input bit inject, input bit exp_err);
        int d0, w0, cyc;
        bit got;
        d0 = done_cnt;
        w0 = wr_cnt;
        start_batch(rows, hb, yb, gb, sc);
        tick();
        if (!spam) start_in = 1'b0;
        num_rows_in  = 8'($urandom);
        h_base_in    = 8'($urandom);
        y_base_in    = 8'($urandom);
        grad_base_in = 8'($urandom);
        inv_bs2_in   = 16'($urandom);
        chk("busy_after_start", busy_out, rows != 0);
        chk("err_cleared_on_start", err_out, 1'b0);
        if (inject) begin
            inj_v2 = 1'b1;
            tick();
            inj_v2 = 1'b0;
            chk("err_on_orphan_col2", err_out, 1'b1);
            chk("no_wr_for_orphan", wr_en_out, 1'b0);
        end
        got = 0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done_out) begin
                got = 1;
                chk("busy_low_at_done", busy_out, 1'b0);
                if (rows == 0) chk("empty_batch_done_latency", cyc, 1);
            end
        end
        if (!got) unexp("done_timeout", cyc);
        tick();
        start_in = 1'b0;
        repeat (4) tick();
        chk("done_pulses", done_cnt - d0, 1);
        chk("write_count", wr_cnt - w0, rows);
        chk("queues_drained", rdq.size() + c1q.size() + c2q.size() + wrq.size(), 0);
        chk("busy_idle", busy_out, 1'b0);
        chk("err_at_end", err_out, exp_err);
    endtask

    task automatic reset_mid_issue();
        int d0, w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        start_batch(6, 8'h80, 8'h90, 8'hA0, 16'h002B);
        tick();
        start_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_outputs_zero", $countones({rd_en_out, rd_h_addr_out, rd_y_addr_out, H_1_out,
            Y_1_out, H_2_out, Y_2_out, valid_1_out, valid_2_out, inv_bs2_out, wr_en_out,
            wr_addr_out, wr_data_out, busy_out, done_out, err_out}), 0);
        tick();
        rdq.delete();
        c1q.delete();
        c2q.delete();
        wrq.delete();
        rst = 1'b0;
        repeat (12) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_idle", {busy_out, err_out}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_h[i] = $urandom;
            mem_y[i] = $urandom;
        end
        start_in = 1'b0;
        num_rows_in = '0;
        h_base_in = '0;
        y_base_in = '0;
        grad_base_in = '0;
        inv_bs2_in = '0;
        inj_v2 = 1'b0;
        #2;
        chk("reset_outputs_zero", $countones({rd_en_out, rd_h_addr_out, rd_y_addr_out, H_1_out,
            Y_1_out, H_2_out, Y_2_out, valid_1_out, valid_2_out, inv_bs2_out, wr_en_out,
            wr_addr_out, wr_data_out, busy_out, done_out, err_out}), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_batch(4, 8'h10, 8'h20, 8'h30, 16'h0080, 0, 0, 0);
        run_batch(0, 8'h40, 8'h50, 8'h60, 16'h1234, 0, 0, 0);
        run_batch(3, 8'hFE, 8'hFF, 8'hFE, 16'h0055, 0, 0, 0);
        run_batch(5, 8'h05, 8'h45, 8'h85, 16'h0033, 1, 0, 0);
        run_batch(3, 8'h60, 8'h70, 8'hC0, 16'h0055, 0, 1, 1);
        run_batch(2, 8'h61, 8'h71, 8'hC8, 16'h0080, 0, 0, 0);
        reset_mid_issue();
        run_batch(2, 8'h33, 8'h44, 8'h55, 16'h0100, 0, 0, 0);
        for (int b = 0; b < 6; b++)
            run_batch(int'($urandom_range(1, 12)), 8'($urandom), 8'($urandom), 8'($urandom),
                      16'($urandom_range(1, 16'h0200)), 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
